// File: rtl/ldl_fifo_rs_v2.sv
// rtl/ldl_fifo_rs_v2.sv - FIFO read-side controller with RAM issue, prefetch buffer and occupancy flags
module ldl_fifo_rs_v2 #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int RL    = 1,
  parameter int BUFD  = RL + 1,
  parameter int AE_TH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:0]   w_pt,
  output logic [AW:0]   r_pt,
  output logic          rd_en,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  input  logic          dready,
  input  logic          flush,
  output logic [AW:0]   rcnt,
  output logic          aempty,
  output logic          empty
);

  localparam int CW  = $clog2(BUFD + 1) + 1;
  localparam int BIW = (BUFD > 1) ? $clog2(BUFD) : 1;
  localparam int PW  = (RL > 0) ? RL : 1;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0]  buf_mem [BUFD];
  logic [BIW-1:0] hd;
  logic [BIW-1:0] tl;
  logic [CW-1:0]  buf_cnt;
  logic [CW-1:0]  infl;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic [PW-1:0]  vq;
  logic [AW:0]    r_pt_n;
  logic [AW:0]    rcnt_n;
  logic           mr;
  logic           pop;
  logic           cap;

  function automatic logic [BIW-1:0] bump(input logic [BIW-1:0] x);
    return (x == BIW'(BUFD - 1)) ? '0 : x + 1'b1;
  endfunction

  assign mr     = (w_pt != r_pt);
  assign dvalid = (buf_cnt != '0);
  assign dout   = buf_mem[hd];
  assign pop    = dvalid & dready;
  assign ra     = r_pt[AW-1:0];
  assign cnt    = infl + buf_cnt;

  // Issue only when the buffer will still have a free slot for every outstanding read.
  assign rd_en  = rst & mr & ~flush & ((cnt - CW'(pop)) < CW'(BUFD));

  // With zero latency the data is captured on the issue edge itself.
  assign cap    = (RL == 0) ? rd_en : vq[PW-1];

  // Count reads still travelling through the RAM latency pipe.
  always_comb begin
    infl = '0;
    for (int i = 0; i < PW; i++) infl = infl + CW'(vq[i]);
  end

  // Next-state pointer and occupancy feed the registered count and flags.
  always_comb begin
    r_pt_n = flush ? w_pt : r_pt + (AW+1)'(rd_en);
    cnt_n  = flush ? '0 : cnt + CW'(rd_en) - CW'(pop);
    rcnt_n = (w_pt - r_pt_n) + (AW+1)'(cnt_n);
  end

  // Read pointer advances per issue; flush jumps it to the writer, dropping pending words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pt <= '0;
    else      r_pt <= r_pt_n;
  end

  // Valid shift pipe marking which cycles carry returning RAM data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vq <= '0;
    end else if (flush) begin
      vq <= '0;
    end else begin
      vq[0] <= rd_en & (RL > 0);
      for (int i = 1; i < PW; i++) vq[i] <= vq[i-1];
    end
  end

  // Prefetch ring: capture at tail, pop from head, cleared by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd      <= '0;
      tl      <= '0;
      buf_cnt <= '0;
      for (int i = 0; i < BUFD; i++) buf_mem[i] <= '0;
    end else if (flush) begin
      hd      <= '0;
      tl      <= '0;
      buf_cnt <= '0;
    end else begin
      if (cap) begin
        buf_mem[tl] <= rdata;
        tl          <= bump(tl);
      end
      if (pop) hd <= bump(hd);
      buf_cnt <= buf_cnt + CW'(cap) - CW'(pop);
    end
  end

  // Registered occupancy and flags, one cycle behind the pointer inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt   <= '0;
      empty  <= 1'b1;
      aempty <= 1'b1;
    end else begin
      rcnt   <= rcnt_n;
      empty  <= (rcnt_n == '0);
      aempty <= (int'(rcnt_n) <= AE_TH);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(cap && !flush && !pop && buf_cnt == CW'(BUFD)));

  a_ptr_span: assert property (@(posedge clk) disable iff (!rst)
    (w_pt - r_pt) <= DEPTH);

endmodule

// File: tb/tb_ldl_fifo_rs_v2.sv
// tb/tb_ldl_fifo_rs_v2.sv - self-checking bench for ldl_fifo_rs_v2 at RL=0,1,2
module tb_ldl_fifo_rs_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        dready = 1'b0;
  logic [3:0]  w_pt = '0;
  logic [15:0] ram [8];
  int          wcount = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    logic [3:0]  r_pt;
    logic        rd_en;
    logic [2:0]  ra;
    logic [15:0] rdata;
    logic [15:0] dout;
    logic        dvalid;
    logic [3:0]  rcnt;
    logic        aempty;
    logic        empty;
    logic [3:0]  cp = '0;
    logic [3:0]  cp_n;
    logic [3:0]  exp_rcnt = '0;
    logic [3:0]  span;
    logic        hold = 1'b0;
    int          pops = 0;
    int          issues = 0;

    ldl_fifo_rs_v2 #(.AW(3), .DW(16), .RL(g), .BUFD(g + 1), .AE_TH(2)) dut (
      .clk(clk), .rst(rst), .w_pt(w_pt), .r_pt(r_pt), .rd_en(rd_en), .ra(ra),
      .rdata(rdata), .dout(dout), .dvalid(dvalid), .dready(dready), .flush(flush),
      .rcnt(rcnt), .aempty(aempty), .empty(empty)
    );

    if (g == 0) begin : g_l0
      assign rdata = ram[ra];
    end else begin : g_lq
      logic [15:0] rq [2];
      always @(posedge clk) begin
        rq[0] <= ram[ra];
        rq[1] <= rq[0];
      end
      assign rdata = rq[g-1];
    end

    // cp counts words consumed (popped or discarded); occupancy is w_pt - cp.
    always @(negedge clk) begin
      if (!rst) begin
        chk($sformatf("u%0d.rst_dvalid", g), dvalid, 0);
        chk($sformatf("u%0d.rst_rd_en", g), rd_en, 0);
        chk($sformatf("u%0d.rst_rcnt", g), rcnt, 0);
        chk($sformatf("u%0d.rst_flags", g), {empty, aempty}, 2'b11);
        chk($sformatf("u%0d.rst_r_pt", g), r_pt, 0);
        chk($sformatf("u%0d.rst_dout", g), dout, 0);
        cp = '0;
        exp_rcnt = '0;
        hold = 1'b0;
      end else begin
        chk($sformatf("u%0d.rcnt", g), rcnt, exp_rcnt);
        chk($sformatf("u%0d.empty", g), empty, exp_rcnt == 0);
        chk($sformatf("u%0d.aempty", g), aempty, exp_rcnt <= 2);
        chk($sformatf("u%0d.ra", g), ra, r_pt[2:0]);
        chk($sformatf("u%0d.flush_issue", g), rd_en & flush, 0);
        span = w_pt - r_pt;
        chk($sformatf("u%0d.span", g), span <= 8, 1);
        if (hold) chk($sformatf("u%0d.dvalid_hold", g), dvalid, 1);
        if (dvalid) begin
          chk($sformatf("u%0d.dout", g), dout, ram[cp[2:0]]);
          chk($sformatf("u%0d.dvalid_owned", g), w_pt != cp, 1);
        end
        if (dvalid && dready) pops++;
        if (rd_en) issues++;
        hold = dvalid & ~dready & ~flush;
        cp_n = flush ? w_pt : cp + 4'(dvalid && dready);
        exp_rcnt = w_pt - cp_n;
        cp = cp_n;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input int n);
    logic [2:0] a;
    for (int i = 0; i < n; i++) begin
      a = w_pt[2:0] + 3'(i);
      ram[a] = 16'hD000 + 16'(wcount);
      wcount++;
    end
    w_pt = w_pt + 4'(n);
  endtask

  logic [6:0]  rdv;
  logic [6:0]  dvv;
  logic [11:0] rav;
  logic [8:0]  dv0, dv1, dv2;
  int          b0, b1, b2, nra;

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = '0;
    tick(3);
    rst = 1'b1;
    tick(1);

    // RL=1 timing: four back-to-back issues, data two cycles after w_pt moves
    dready = 1'b1;
    put(4);
    rdv = '0; dvv = '0; rav = '0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      rdv = {rdv[5:0], gi[1].rd_en};
      dvv = {dvv[5:0], gi[1].dvalid};
      if (c < 4) rav = {rav[8:0], gi[1].ra};
      if (c == 2) chk("t1.first_dout", gi[1].dout, 16'hD000);
    end
    chk("t1.rd_en_seq", rdv, 7'b1111000);
    chk("t1.dvalid_seq", dvv, 7'b0011110);
    chk("t1.ra_seq", rav, 12'h053);
    chk("t1.r_pt", gi[1].r_pt, 4);
    chk("t1.rcnt", gi[1].rcnt, 0);
    chk("t1.empty", gi[1].empty, 1);
    tick(3);

    // Stalled consumer: issues stop at the buffer depth, head held
    dready = 1'b0;
    b0 = gi[0].issues; b1 = gi[1].issues; b2 = gi[2].issues;
    put(8);
    tick(10);
    @(negedge clk);
    chk("t2.issues_rl2", gi[2].issues - b2, 3);
    chk("t2.issues_rl1", gi[1].issues - b1, 2);
    chk("t2.issues_rl0", gi[0].issues - b0, 1);
    chk("t2.rd_en", gi[2].rd_en, 0);
    chk("t2.dvalid", gi[2].dvalid, 1);
    chk("t2.dout", gi[2].dout, 16'hD004);
    chk("t2.rcnt_full", gi[2].rcnt, 8);
    chk("t2.flags_full", {gi[2].empty, gi[2].aempty}, 2'b00);
    tick(1);
    dready = 1'b1;
    dv0 = '0; dv1 = '0; dv2 = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      dv0 = {dv0[7:0], gi[0].dvalid};
      dv1 = {dv1[7:0], gi[1].dvalid};
      dv2 = {dv2[7:0], gi[2].dvalid};
    end
    chk("t2.stream_rl0", dv0, 9'h1FE);
    chk("t2.stream_rl1", dv1, 9'h1FE);
    chk("t2.stream_rl2", dv2, 9'h1FE);
    tick(2);

    // Full depth is 8 not 0; drain to 2 then to 0
    dready = 1'b0;
    put(8);
    tick(10);
    @(negedge clk);
    chk("t3.rcnt8", gi[1].rcnt, 8);
    chk("t3.flags8", {gi[1].empty, gi[1].aempty}, 2'b00);
    tick(1);
    dready = 1'b1;
    tick(6);
    dready = 1'b0;
    @(negedge clk);
    chk("t3.rcnt2", gi[2].rcnt, 2);
    chk("t3.flags2", {gi[2].empty, gi[2].aempty}, 2'b01);
    tick(1);
    dready = 1'b1;
    tick(2);
    @(negedge clk);
    chk("t3.rcnt0", gi[0].rcnt, 0);
    chk("t3.flags0", {gi[0].empty, gi[0].aempty}, 2'b11);
    tick(3);

    // Wrap: r_pt 6 -> 10 reads addresses 6,7,0,1
    put(2);
    tick(6);
    put(4);
    rav = '0; nra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gi[1].rd_en) begin
        rav = {rav[8:0], gi[1].ra};
        nra++;
      end
    end
    chk("t4.ra_count", nra, 4);
    chk("t4.ra_seq", rav, 12'hDC1);
    chk("t4.r_pt", gi[1].r_pt, 4'b1010);
    tick(3);

    // Flush after two issues with five pending
    dready = 1'b0;
    put(5);
    tick(2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    chk("t5.dvalid", gi[2].dvalid, 0);
    chk("t5.rcnt", gi[2].rcnt, 0);
    chk("t5.r_pt", gi[2].r_pt, 4'hF);
    chk("t5.r_pt_rl0", gi[0].r_pt, 4'hF);
    tick(3);
    @(negedge clk);
    chk("t5.stale_rl2", gi[2].dvalid, 0);
    chk("t5.stale_rl1", gi[1].dvalid, 0);
    tick(1);
    b0 = gi[0].pops; b1 = gi[1].pops; b2 = gi[2].pops;
    dready = 1'b1;
    put(1);
    tick(6);
    @(negedge clk);
    chk("t5.one_rl2", gi[2].pops - b2, 1);
    chk("t5.one_rl1", gi[1].pops - b1, 1);
    chk("t5.one_rl0", gi[0].pops - b0, 1);
    tick(1);

    // Flush coinciding with a pop
    put(3);
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    @(negedge clk);
    chk("t5b.rcnt", gi[2].rcnt, 0);
    chk("t5b.dvalid", gi[1].dvalid, 0);
    tick(2);

    // Asynchronous reset mid-burst, restart from address 0
    put(4);
    tick(1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6.dvalid", {gi[0].dvalid, gi[1].dvalid, gi[2].dvalid}, 3'b000);
    chk("t6.rd_en", {gi[0].rd_en, gi[1].rd_en, gi[2].rd_en}, 3'b000);
    chk("t6.rcnt", gi[2].rcnt, 0);
    chk("t6.flags", {gi[1].empty, gi[1].aempty}, 2'b11);
    chk("t6.r_pt", gi[1].r_pt, 0);
    w_pt = '0;
    put(3);
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    chk("t6.restart_en", gi[1].rd_en, 1);
    chk("t6.restart_ra", gi[1].ra, 0);
    tick(8);
    @(negedge clk);
    chk("t6.drained", {gi[0].empty, gi[1].empty, gi[2].empty}, 3'b111);
    chk("t6.r_pt_end", gi[2].r_pt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
